clock_period_meter: RTL and testbench
=====================================

// Module: clock_period_meter
// PURPOSE
//  Measures the period of a slow, possibly asynchronous square wave in CLKin cycles.
//  Typical source is the divided clkout of the frequency divider (1 Hz from 50 MHz) or an external pin.
//  Synchronises sig_in and detects its rising edges. Reports each completed period with a one-cycle
//  valid strobe, flags loss of signal via timeout, and emits a one-cycle edge_tick usable as a clock enable.
// PARAMETERS
//  CNT_W       32          width of period counter and period output
//  TIMEOUT     50000000    CLKin cycles without a rise before timeout (>= MIN_PERIOD+1)
//  SYNC_STAGES 2           synchroniser flops on sig_in (>= 2)
//  MIN_PERIOD  4           rises closer than this many cycles to the previous rise are glitches
// PORTS
//  CLKin        in   1      system clock, all logic on posedge
//  clr          in   1      asynchronous reset, active-low (0 = reset)
//  en           in   1      measurement enable, synchronous
//  sig_in       in   1      signal under measurement, asynchronous to CLKin
//  edge_tick    out  1      one-cycle pulse per synchronised rise of sig_in
//  period       out  CNT_W  last measured period in CLKin cycles
//  period_valid out  1      one-cycle strobe when period updates
//  locked       out  1      high once at least one valid period has been reported
//  timeout      out  1      level: no rise seen for TIMEOUT cycles
// BEHAVIOUR
//  Reset (clr=0, any time, async):
//   - Sync chain, edge register p, cnt and all outputs go to 0; state goes to IDLE.
//   - An in-flight measurement is discarded.
//  Edge detect:
//   - s[0..SYNC_STAGES-1] shift sig_in; rise = s[last] & ~p; p <= s[last].
//   - edge_tick is registered. It is high for exactly 1 cycle, on edge SYNC_STAGES+1, counting the
//     first CLKin edge that samples sig_in=1 as edge 1.
//   - edge_tick fires in every state except IDLE, including on glitch rises.
//  FSM states: IDLE, ARM, MEASURE, TMO.
//   - IDLE: cnt=0, locked=0, timeout=0. en=1 -> ARM.
//   - ARM: waits for the first rise. rise -> MEASURE with cnt=0; no period_valid, since the interval
//     before the first rise is unknown.
//   - MEASURE: cnt increments each cycle and saturates at all-ones.
//     - rise with cnt+1 >= MIN_PERIOD: period<=cnt+1, period_valid=1 next cycle, locked<=1, cnt<=0.
//     - rise with cnt+1 < MIN_PERIOD: ignored for measurement; cnt keeps counting.
//     - cnt+1 == TIMEOUT with no valid rise: -> TMO, timeout<=1, locked<=0; period holds its value.
//     - Valid rise and timeout threshold in the same cycle: the rise wins, no timeout.
//   - TMO: timeout stays high and cnt is held at 0. rise -> MEASURE with cnt=0 and timeout<=0; that rise
//     produces no period_valid.
//  en=0 in any state:
//   - Next cycle: state IDLE, cnt=0, locked=0, timeout=0, period_valid=0; period holds its value.
//  period_valid never asserts on two consecutive cycles (MIN_PERIOD >= 2 enforced).
//  period_valid and period update together, 1 cycle after the cycle in which rise is detected.
//  Latency from sig_in rise to period_valid: SYNC_STAGES+1 CLKin edges.
// TESTING
//  1. Bench params TIMEOUT=100, MIN_PERIOD=4. Reset, en=1, sig_in toggles every 10 cycles:
//     edge_tick every 20 cycles; period=20 with period_valid from the 2nd rise on; locked=1 after the
//     first valid.
//  2. sig_in stops toggling after locking:
//     exactly 100 cycles after the last rise, timeout=1 and locked=0, period stays 20.
//     Restart toggling: first rise clears timeout with no valid; next rise gives period_valid, period=20.
//  3. Glitch: rise, a 1-cycle low then high 2 cycles after the rise, then the next true rise 30 cycles
//     after the first: edge_tick fires for the glitch; period=30, a single valid.
//  4. Pull clr low mid-period (cnt ~15): all outputs 0 immediately.
//     Release with en=1: ARM; first rise gives no valid; second rise gives valid with the true period.
//  5. en=0 for 5 cycles while locked: locked, timeout, period_valid go 0 next cycle; period holds.
//     en=1: behaves like a fresh ARM.
//  6. Period exactly 100 = TIMEOUT: the rise lands on the threshold cycle, so period=100 with valid and
//     timeout stays 0.

Source files
------------

// File: rtl/clock_period_meter_if.sv
// Signal bundle for clock_period_meter: measurement controls in, edge/period/status reports out.
// The master side drives en and sig_in. The slave side is the meter.
interface clock_period_meter_if #(
    parameter int CNT_W = 32
);
    logic             en;
    logic             sig_in;
    logic             edge_tick;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    modport master (
        output en, sig_in,
        input  edge_tick, period, period_valid, locked, timeout
    );

    modport slave (
        input  en, sig_in,
        output edge_tick, period, period_valid, locked, timeout
    );
endinterface

// File: rtl/clock_period_meter.sv
// Measures the period of a slow asynchronous square wave in CLKin cycles between synchronised rises.
// Rises that come too soon are rejected as glitches, and a missing rise is reported as a timeout.
module clock_period_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 50000000,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PERIOD  = 4
) (
    input  logic                  CLKin,
    input  logic                  clr,
    clock_period_meter_if.slave   bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] TMO     = 2'd3;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

    if (SYNC_STAGES < 2 || MIN_PERIOD < 2 || TIMEOUT < MIN_PERIOD + 1) begin : g_param_check
        $error("clock_period_meter: SYNC_STAGES>=2, MIN_PERIOD>=2, TIMEOUT>MIN_PERIOD required");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   p;
    logic                   rise;
    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_sat;
    logic                   edge_tick_q;
    logic [CNT_W-1:0]       period_q;
    logic                   period_valid_q;
    logic                   locked_q;
    logic                   timeout_q;

    assign rise    = sync[SYNC_STAGES-1] & ~p;
    // cnt+1 that sticks at all-ones, so a very long period cannot wrap back to a short one
    assign cnt_sat = (&cnt) ? cnt : cnt + CNT_W'(1);

    // NOTE: every register here is assigned with <=, so all of them sample pre-edge values together.
    always_ff @(posedge CLKin or negedge clr) begin
        if (!clr) begin
            sync <= '0;
            p    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.sig_in};
            p    <= sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge CLKin or negedge clr) begin
        if (!clr) begin
            state          <= IDLE;
            cnt            <= '0;
            edge_tick_q    <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            edge_tick_q    <= rise && (state != IDLE);
            if (!bus.en) begin
                state     <= IDLE;
                cnt       <= '0;
                locked_q  <= 1'b0;
                timeout_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt       <= '0;
                        locked_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        state     <= ARM;
                    end
                    ARM: begin
                        // the interval before the first rise is unknown, so that rise only starts counting
                        if (rise) begin
                            state <= MEASURE;
                            cnt   <= '0;
                        end
                    end
                    MEASURE: begin
                        if (rise && cnt_sat >= MIN_C) begin
                            period_q       <= cnt_sat;
                            period_valid_q <= 1'b1;
                            locked_q       <= 1'b1;
                            cnt            <= '0;
                        end else if (cnt_sat == TMO_C) begin
                            state     <= TMO;
                            timeout_q <= 1'b1;
                            locked_q  <= 1'b0;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt_sat;
                        end
                    end
                    TMO: begin
                        cnt <= '0;
                        if (rise) begin
                            state     <= MEASURE;
                            timeout_q <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.edge_tick    = edge_tick_q;
    assign bus.period       = period_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = locked_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed bench for clock_period_meter with TIMEOUT=100 and MIN_PERIOD=4.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_clock_period_meter;

    logic clk;
    logic clr;

    clock_period_meter_if #(.CNT_W(32)) bus ();

    clock_period_meter #(
        .CNT_W(32), .TIMEOUT(100), .SYNC_STAGES(2), .MIN_PERIOD(4)
    ) dut (
        .CLKin(clk),
        .clr  (clr),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc_no = 0;
    int          n_tick, n_valid, n_tmo;
    int          first_tick, last_tick, valid_cyc;
    logic [31:0] last_per;

    task automatic clear_counts();
        n_tick = 0; n_valid = 0; n_tmo = 0;
        first_tick = -1; last_tick = -1; valid_cyc = -1; last_per = '0;
    endtask

    // One CLKin cycle with sig_in held at s; records what the outputs show afterwards.
    task automatic cyc(input logic s);
        bus.sig_in = s;
        @(negedge clk);
        cyc_no++;
        if (bus.edge_tick) begin
            if (n_tick == 0) first_tick = cyc_no;
            n_tick++;
            last_tick = cyc_no;
        end
        if (bus.period_valid) begin
            n_valid++;
            last_per  = bus.period;
            valid_cyc = cyc_no;
        end
        if (bus.timeout) n_tmo++;
    endtask

    task automatic run(input logic s, input int n);
        for (int i = 0; i < n; i++) cyc(s);
    endtask

    task automatic square(input int half, input int rises);
        for (int i = 0; i < rises; i++) begin
            run(1'b1, half);
            run(1'b0, half);
        end
    endtask

    task automatic restart();
        clr = 1'b0;
        run(1'b0, 2);
        clr = 1'b1;
        bus.en = 1'b1;
        run(1'b0, 2);
        clear_counts();
    endtask

    task automatic test_reset();
        clr = 1'b1; bus.en = 1'b0; bus.sig_in = 1'b0;
        #3 clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.edge_tick !== 1'b0) begin bad++; $display("FAIL reset_edge_tick: got %b want 0", bus.edge_tick); end
        total++; if (bus.period !== 32'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", bus.period); end
        total++; if (bus.period_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.period_valid); end
        total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", bus.locked); end
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", bus.timeout); end
    endtask

    task automatic test_basic();
        int base;
        clr = 1'b1;
        bus.en = 1'b1;
        run(1'b0, 2);
        clear_counts();
        base = cyc_no;
        square(10, 5);
        total++; if (first_tick !== base + 3) begin bad++; $display("FAIL basic_tick_latency: got %0d want %0d", first_tick - base, 3); end
        total++; if (n_tick !== 5) begin bad++; $display("FAIL basic_tick_count: got %0d want 5", n_tick); end
        total++; if (last_tick - first_tick !== 80) begin bad++; $display("FAIL basic_tick_spacing: got %0d want 80", last_tick - first_tick); end
        total++; if (n_valid !== 4) begin bad++; $display("FAIL basic_valid_count: got %0d want 4", n_valid); end
        total++; if (last_per !== 32'd20) begin bad++; $display("FAIL basic_period: got %0d want 20", last_per); end
        total++; if (valid_cyc !== last_tick) begin bad++; $display("FAIL basic_valid_align: got %0d want %0d", valid_cyc, last_tick); end
        total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL basic_locked: got %b want 1", bus.locked); end
    endtask

    task automatic test_timeout();
        int guard = 0;
        while (!bus.timeout && guard < 300) begin
            cyc(1'b0);
            guard++;
        end
        total++;
        if (bus.timeout !== 1'b1) begin
            bad++; $display("FAIL tmo_never_set: got %b want 1", bus.timeout);
        end else if (cyc_no - last_tick !== 100) begin
            bad++; $display("FAIL tmo_delay: got %0d want 100", cyc_no - last_tick);
        end
        total++; if (bus.locked !== 1'b0) begin bad++; $display("FAIL tmo_locked: got %b want 0", bus.locked); end
        total++; if (bus.period !== 32'd20) begin bad++; $display("FAIL tmo_period_hold: got %0d want 20", bus.period); end
        run(1'b0, 20);
        total++; if (bus.timeout !== 1'b1) begin bad++; $display("FAIL tmo_level: got %b want 1", bus.timeout); end
        clear_counts();
        run(1'b1, 10);
        total++; if (bus.timeout !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b want 0", bus.timeout); end
        total++; if (n_valid !== 0) begin bad++; $display("FAIL tmo_first_rise_valid: got %0d want 0", n_valid); end
        total++; if (n_tick !== 1) begin bad++; $display("FAIL tmo_first_rise_tick: got %0d want 1", n_tick); end
        run(1'b0, 10);
        run(1'b1, 10);
        total++; if (n_valid !== 1 || last_per !== 32'd20) begin bad++; $display("FAIL tmo_relock: got n=%0d per=%0d want n=1 per=20", n_valid, last_per); end
    endtask

    task automatic test_glitch();
        restart();
        run(1'b1, 5); run(1'b0, 25);
        cyc(1'b1); cyc(1'b0); run(1'b1, 8); run(1'b0, 20);
        total++; if (n_tick !== 3) begin bad++; $display("FAIL glitch_ticks: got %0d want 3", n_tick); end
        total++; if (n_valid !== 1 || last_per !== 32'd30) begin bad++; $display("FAIL glitch_first: got n=%0d per=%0d want n=1 per=30", n_valid, last_per); end
        run(1'b1, 5); run(1'b0, 5);
        total++; if (n_tick !== 4) begin bad++; $display("FAIL glitch_ticks_end: got %0d want 4", n_tick); end
        total++; if (n_valid !== 2 || last_per !== 32'd30) begin bad++; $display("FAIL glitch_period: got n=%0d per=%0d want n=2 per=30", n_valid, last_per); end
    endtask

    task automatic test_min_period();
        restart();
        for (int i = 0; i < 4; i++) begin
            run(1'b1, 2);
            run(1'b0, 2);
        end
        run(1'b0, 4);
        total++; if (n_valid !== 3 || last_per !== 32'd4) begin bad++; $display("FAIL minper: got n=%0d per=%0d want n=3 per=4", n_valid, last_per); end
    endtask

    task automatic test_async_clear();
        restart();
        square(10, 2);
        total++; if (bus.locked !== 1'b1) begin bad++; $display("FAIL clr_pre_locked: got %b want 1", bus.locked); end
        clr = 1'b0;
        #1;
        total++; if (bus.locked !== 1'b0 || bus.period !== 32'd0 || bus.period_valid !== 1'b0 ||
                     bus.edge_tick !== 1'b0 || bus.timeout !== 1'b0) begin
            bad++; $display("FAIL clr_immediate: got lk=%b per=%0d v=%b t=%b to=%b want all 0",
                            bus.locked, bus.period, bus.period_valid, bus.edge_tick, bus.timeout);
        end
        @(negedge clk);
        clr = 1'b1;
        run(1'b0, 2);
        clear_counts();
        run(1'b1, 8); run(1'b0, 8);
        total++; if (n_valid !== 0) begin bad++; $display("FAIL clr_first_rise: got %0d want 0", n_valid); end
        run(1'b1, 8); run(1'b0, 8);
        total++; if (n_valid !== 1 || last_per !== 32'd16) begin bad++; $display("FAIL clr_period: got n=%0d per=%0d want n=1 per=16", n_valid, last_per); end
    endtask

    task automatic test_enable();
        clear_counts();
        bus.en = 1'b0;
        cyc(1'b0);
        total++; if (bus.locked !== 1'b0 || bus.timeout !== 1'b0 || bus.period_valid !== 1'b0) begin
            bad++; $display("FAIL en_off: got lk=%b to=%b v=%b want 0 0 0", bus.locked, bus.timeout, bus.period_valid);
        end
        total++; if (bus.period !== 32'd16) begin bad++; $display("FAIL en_period_hold: got %0d want 16", bus.period); end
        run(1'b1, 4);
        total++; if (n_tick !== 0) begin bad++; $display("FAIL en_idle_tick: got %0d want 0", n_tick); end
        bus.en = 1'b1;
        run(1'b0, 8);
        run(1'b1, 8); run(1'b0, 8);
        total++; if (n_valid !== 0) begin bad++; $display("FAIL en_first_rise: got %0d want 0", n_valid); end
        run(1'b1, 8); run(1'b0, 2);
        total++; if (n_valid !== 1 || last_per !== 32'd16 || bus.locked !== 1'b1) begin
            bad++; $display("FAIL en_rearm: got n=%0d per=%0d lk=%b want n=1 per=16 lk=1", n_valid, last_per, bus.locked);
        end
    endtask

    task automatic test_threshold();
        restart();
        square(50, 3);
        total++; if (n_valid !== 2 || last_per !== 32'd100) begin bad++; $display("FAIL thr_period: got n=%0d per=%0d want n=2 per=100", n_valid, last_per); end
        total++; if (n_tmo !== 0) begin bad++; $display("FAIL thr_timeout: got %0d cycles want 0", n_tmo); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_glitch();
        test_min_period();
        test_async_clear();
        test_enable();
        test_threshold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
